// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two ROM requesters, the arbiter and the single genrom read port.
interface rom_port_arbiter_if #(
  parameter int unsigned MEM_ADDR  = 6,
  parameter int unsigned MEM_EXTRA = 4
) ();
  localparam int unsigned AW = MEM_ADDR + 1;
  localparam int unsigned DW = (1 << MEM_EXTRA) * 8;

  // Requester 0 (instruction fetch)
  logic                 p0_req;
  logic [AW-1:0]        p0_addr;
  logic [MEM_EXTRA-1:0] p0_extra;
  logic [AW-1:0]        p0_lower_bound;
  logic [AW-1:0]        p0_upper_bound;
  logic                 p0_ack;
  logic [DW-1:0]        p0_data;
  logic                 p0_error;

  // Requester 1 (data / loader reads)
  logic                 p1_req;
  logic [AW-1:0]        p1_addr;
  logic [MEM_EXTRA-1:0] p1_extra;
  logic [AW-1:0]        p1_lower_bound;
  logic [AW-1:0]        p1_upper_bound;
  logic                 p1_ack;
  logic [DW-1:0]        p1_data;
  logic                 p1_error;

  // ROM side
  logic [AW-1:0]        mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [AW-1:0]        mem_lower_bound;
  logic [AW-1:0]        mem_upper_bound;
  logic [DW-1:0]        mem_data;
  logic                 mem_error;

  logic                 busy;

  // Arbiter view
  modport slave (
    input  p0_req, p0_addr, p0_extra, p0_lower_bound, p0_upper_bound,
    output p0_ack, p0_data, p0_error,
    input  p1_req, p1_addr, p1_extra, p1_lower_bound, p1_upper_bound,
    output p1_ack, p1_data, p1_error,
    output mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
    input  mem_data, mem_error,
    output busy
  );

  // Requester + ROM view
  modport master (
    output p0_req, p0_addr, p0_extra, p0_lower_bound, p0_upper_bound,
    input  p0_ack, p0_data, p0_error,
    output p1_req, p1_addr, p1_extra, p1_lower_bound, p1_upper_bound,
    input  p1_ack, p1_data, p1_error,
    input  mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
    output mem_data, mem_error,
    input  busy
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one genrom read port between two requesters.
// One access outstanding at a time; all ROM-side and response outputs are registered.
module rom_port_arbiter #(
  parameter int unsigned MEM_ADDR    = 6,
  parameter int unsigned MEM_EXTRA   = 4,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  rom_port_arbiter_if.slave io_bus
);
  localparam int unsigned AW = MEM_ADDR + 1;
  localparam int unsigned DW = (1 << MEM_EXTRA) * 8;
  localparam int unsigned CW = $clog2(ROM_LATENCY + 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e               r_state, w_state;
  logic                 r_owner, w_owner;
  logic                 r_last_grant, w_last_grant;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic [AW-1:0]        r_mem_addr, w_mem_addr;
  logic [MEM_EXTRA-1:0] r_mem_extra, w_mem_extra;
  logic [AW-1:0]        r_mem_lb, w_mem_lb;
  logic [AW-1:0]        r_mem_ub, w_mem_ub;
  logic                 r_p0_ack, w_p0_ack;
  logic                 r_p1_ack, w_p1_ack;
  logic [DW-1:0]        r_p0_data, w_p0_data;
  logic [DW-1:0]        r_p1_data, w_p1_data;
  logic                 r_p0_error, w_p0_error;
  logic                 r_p1_error, w_p1_error;
  logic                 w_grant;

  // Next-state: grant in IDLE, count down latency in WAIT and deliver to the owner.
  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_last_grant = r_last_grant;
    w_cnt        = r_cnt;
    w_mem_addr   = r_mem_addr;
    w_mem_extra  = r_mem_extra;
    w_mem_lb     = r_mem_lb;
    w_mem_ub     = r_mem_ub;
    w_p0_ack     = 1'b0;
    w_p1_ack     = 1'b0;
    w_p0_data    = r_p0_data;
    w_p1_data    = r_p1_data;
    w_p0_error   = r_p0_error;
    w_p1_error   = r_p1_error;
    w_grant      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.p0_req || io_bus.p1_req) begin
          // On a tie the port that did not win last time gets the ROM.
          w_grant = (io_bus.p0_req && io_bus.p1_req) ? ~r_last_grant : io_bus.p1_req;
          if (w_grant) begin
            w_mem_addr  = io_bus.p1_addr;
            w_mem_extra = io_bus.p1_extra;
            w_mem_lb    = io_bus.p1_lower_bound;
            w_mem_ub    = io_bus.p1_upper_bound;
          end else begin
            w_mem_addr  = io_bus.p0_addr;
            w_mem_extra = io_bus.p0_extra;
            w_mem_lb    = io_bus.p0_lower_bound;
            w_mem_ub    = io_bus.p0_upper_bound;
          end
          w_owner      = w_grant;
          w_last_grant = w_grant;
          w_cnt        = CW'(ROM_LATENCY);
          w_state      = StWait;
        end
      end
      StWait: begin
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          if (r_owner) begin
            w_p1_data  = io_bus.mem_data;
            w_p1_error = io_bus.mem_error;
            w_p1_ack   = 1'b1;
          end else begin
            w_p0_data  = io_bus.mem_data;
            w_p0_error = io_bus.mem_error;
            w_p0_ack   = 1'b1;
          end
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_extra  <= '0;
      r_mem_lb     <= '0;
      r_mem_ub     <= '1;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_p0_data    <= '0;
      r_p1_data    <= '0;
      r_p0_error   <= 1'b0;
      r_p1_error   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_last_grant <= w_last_grant;
      r_cnt        <= w_cnt;
      r_mem_addr   <= w_mem_addr;
      r_mem_extra  <= w_mem_extra;
      r_mem_lb     <= w_mem_lb;
      r_mem_ub     <= w_mem_ub;
      r_p0_ack     <= w_p0_ack;
      r_p1_ack     <= w_p1_ack;
      r_p0_data    <= w_p0_data;
      r_p1_data    <= w_p1_data;
      r_p0_error   <= w_p0_error;
      r_p1_error   <= w_p1_error;
    end
  end

  assign io_bus.mem_addr        = r_mem_addr;
  assign io_bus.mem_extra       = r_mem_extra;
  assign io_bus.mem_lower_bound = r_mem_lb;
  assign io_bus.mem_upper_bound = r_mem_ub;
  assign io_bus.p0_ack          = r_p0_ack;
  assign io_bus.p1_ack          = r_p1_ack;
  assign io_bus.p0_data         = r_p0_data;
  assign io_bus.p1_data         = r_p1_data;
  assign io_bus.p0_error        = r_p0_error;
  assign io_bus.p1_error        = r_p1_error;
  assign io_bus.busy            = (r_state == StWait);
endmodule
